// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU memory bus responders: word geometry and
// the responder state encoding.
package mem_bus_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_OFFSET = 2;
  localparam int unsigned STATE_W     = 2;

  // Responder FSM encoding
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT    = 2'd1;
  localparam logic [STATE_W-1:0] ST_ACK     = 2'd2;
  localparam logic [STATE_W-1:0] ST_RECOVER = 2'd3;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Ports:
//   clk, rst_n      clock / async active-low reset (read register only)
//   i_we            write i_wdata to i_addr on this edge
//   i_re            load read register from i_addr on this edge
//   i_rclr          load read register with zero (takes priority over i_re)
//   i_addr          word index
//   i_wdata         write word
//   o_rdata         read register; holds its value until the next i_re/i_rclr
module mem_responder_ram
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_rclr,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  // Storage array is never reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register; zero-load is used for reads that miss the region
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_rclr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Slave end of the CPU memory bus. Accepts level-held mem_read/mem_write
// requests, inserts WAIT_CYCLES wait states and answers with a one-cycle
// mem_ack. Backed by an on-chip RAM of DEPTH_WORDS words at BASE_ADDR.
// Ports:
//   clk             system clock
//   reset           asynchronous active-low reset
//   mem_read        read request, held until ack
//   mem_write       write request, held until ack (wins if both set)
//   mem_addr        byte address, bits [1:0] ignored
//   mem_write_data  write word
//   mem_ack         one-cycle completion pulse
//   mem_read_data   read word, valid in ack cycle, held until next read ack
//   debug_hex       {word index[15:0], data[15:0]} of last completed
//                   transaction; present only with MEM_RESPONDER_DEBUG_EN
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_write_data,
  output logic              mem_ack,
  output logic [WORD_W-1:0] mem_read_data
`ifdef MEM_RESPONDER_DEBUG_EN
  ,
  output logic [31:0]       debug_hex
`endif
);

  localparam int unsigned AW           = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] REGION_BYTES = 33'(DEPTH_WORDS) << BYTE_OFFSET;
  localparam logic [3:0]  WAIT_LOAD    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [3:0]         r_cnt;
  logic [3:0]         w_next_cnt;
  logic               r_ack;

  logic               r_is_write;
  logic               r_in_range;
  logic [AW-1:0]      r_idx;
  logic [WORD_W-1:0]  r_wdata;

  logic               w_req;
  logic [32:0]        w_diff;
  logic               w_in_range;
  logic [AW-1:0]      w_idx;
  logic               w_enter_ack;
  logic               w_cur_write;
  logic               w_cur_in_range;
  logic [AW-1:0]      w_cur_idx;
  logic [WORD_W-1:0]  w_cur_wdata;
  logic [WORD_W-1:0]  w_ram_rdata;

  // Address decode: a 33-bit difference makes below-base addresses huge,
  // so one compare covers both region bounds.
  assign w_req      = mem_read | mem_write;
  assign w_diff     = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_diff < REGION_BYTES);
  assign w_idx      = w_diff[BYTE_OFFSET +: AW];

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            w_next_state = ST_ACK;
          end else begin
            w_next_state = ST_WAIT;
            w_next_cnt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_ACK;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_ACK:     w_next_state = ST_RECOVER;
      ST_RECOVER: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_ack   <= w_enter_ack;
    end
  end

  // Request capture on acceptance; later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_write <= 1'b0;
      r_in_range <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_is_write <= mem_write;
      r_in_range <= w_in_range;
      r_idx      <= w_idx;
      r_wdata    <= mem_write_data;
    end
  end

  // With zero wait states ACK is entered straight from IDLE, before the
  // capture registers are loaded, so the RAM takes the live request then.
  assign w_enter_ack    = (w_next_state == ST_ACK);
  assign w_cur_write    = (r_state == ST_IDLE) ? mem_write      : r_is_write;
  assign w_cur_in_range = (r_state == ST_IDLE) ? w_in_range     : r_in_range;
  assign w_cur_idx      = (r_state == ST_IDLE) ? w_idx          : r_idx;
  assign w_cur_wdata    = (r_state == ST_IDLE) ? mem_write_data : r_wdata;

  mem_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset),
    .i_we   (w_enter_ack & w_cur_write & w_cur_in_range),
    .i_re   (w_enter_ack & ~w_cur_write & w_cur_in_range),
    .i_rclr (w_enter_ack & ~w_cur_write & ~w_cur_in_range),
    .i_addr (w_cur_idx),
    .i_wdata(w_cur_wdata),
    .o_rdata(w_ram_rdata)
  );

  assign mem_ack       = r_ack;
  assign mem_read_data = w_ram_rdata;

`ifdef MEM_RESPONDER_DEBUG_EN
  logic [15:0] r_idx16;
  logic [31:0] r_debug_hex;

  // Full 16-bit index, even for addresses outside the region
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx16 <= '0;
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_idx16 <= w_diff[BYTE_OFFSET +: 16];
    end
  end

  // Captures the completed transaction at the end of the ACK cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_debug_hex <= '0;
    end else if (r_state == ST_ACK) begin
      r_debug_hex <= {r_idx16, r_is_write ? r_wdata[15:0] : w_ram_rdata[15:0]};
    end
  end

  assign debug_hex = r_debug_hex;
`else
  // Debug display tap not built
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2 wait states; 0 wait states;
// small region at 0x1000 with 1 wait state) driven one at a time.
module tb_mem_responder;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;
  localparam int unsigned W2 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        ack  [3];
  logic [31:0] rdat [3];
`ifdef MEM_RESPONDER_DEBUG_EN
  logic [31:0] dbg  [3];
`endif

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } op_t;

  exp_t sb [$];

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .reset(rst_n), .mem_read(rd[0]), .mem_write(wr[0]), .mem_addr(addr[0]),
    .mem_write_data(wdat[0]), .mem_ack(ack[0]), .mem_read_data(rdat[0])
`ifdef MEM_RESPONDER_DEBUG_EN
    , .debug_hex(dbg[0])
`endif
  );

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1), .BASE_ADDR(32'h0000_0000)) u1 (
    .clk(clk), .reset(rst_n), .mem_read(rd[1]), .mem_write(wr[1]), .mem_addr(addr[1]),
    .mem_write_data(wdat[1]), .mem_ack(ack[1]), .mem_read_data(rdat[1])
`ifdef MEM_RESPONDER_DEBUG_EN
    , .debug_hex(dbg[1])
`endif
  );

  mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(W2), .BASE_ADDR(32'h0000_1000)) u2 (
    .clk(clk), .reset(rst_n), .mem_read(rd[2]), .mem_write(wr[2]), .mem_addr(addr[2]),
    .mem_write_data(wdat[2]), .mem_ack(ack[2]), .mem_read_data(rdat[2])
`ifdef MEM_RESPONDER_DEBUG_EN
    , .debug_hex(dbg[2])
`endif
  );

  // Cycles from presenting an idle-state request up to and including the ack cycle
  function automatic int exp_lat(input int sel);
    case (sel)
      0:       return int'(W0) + 2;
      1:       return int'(W1) + 2;
      default: return int'(W2) + 2;
    endcase
  endfunction

  function automatic op_t mk(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] e);
    op_t o;
    o.r = r; o.w = w; o.a = a; o.d = d; o.e = e;
    return o;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and waits (bounded) for ack; lat = -1 on timeout
  task automatic run_txn(input int sel, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rdo,
                         output longint acyc);
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wdat[sel] = d;
    lat = -1; rdo = '0; acyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ack[sel]) begin
        lat = n + 1; rdo = rdat[sel]; acyc = cyc;
        break;
      end
    end
    rd[sel] = 1'b0; wr[sel] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if (ack[s] !== 1'b0) begin n_bad++; $display("FAIL reset_ack[%0d]: got %b want 0", s, ack[s]); end
      n_cmp++;
      if (rdat[s] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdat[s]); end
`ifdef MEM_RESPONDER_DEBUG_EN
      n_cmp++;
      if (dbg[s] !== 32'h0) begin n_bad++; $display("FAIL reset_debug[%0d]: got %h want 0", s, dbg[s]); end
`endif
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_wait2;
    op_t ops [$];
    exp_t e; int lat; logic [31:0] rv; longint ac;
    ops.push_back(mk(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF));
    ops.push_back(mk(1'b1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF));
    foreach (ops[i]) begin
      idle(2);
      e.data = ops[i].e; e.lat = exp_lat(0); sb.push_back(e);
      run_txn(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, lat, rv, ac);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL wait2[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (rv !== e.data) begin n_bad++; $display("FAIL wait2[%0d] rdata: got %h want %h", i, rv, e.data); end
    end
  endtask

  task automatic test_both_req;
    op_t ops [$];
    exp_t e; int lat; logic [31:0] rv; longint ac;
    ops.push_back(mk(1'b1, 1'b1, 32'h08, 32'h0000_1234, 32'hDEAD_BEEF));
    ops.push_back(mk(1'b1, 1'b0, 32'h08, 32'h0, 32'h0000_1234));
    ops.push_back(mk(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF));
    foreach (ops[i]) begin
      idle(2);
      e.data = ops[i].e; e.lat = exp_lat(0); sb.push_back(e);
      run_txn(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, lat, rv, ac);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL both[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (rv !== e.data) begin n_bad++; $display("FAIL both[%0d] rdata: got %h want %h", i, rv, e.data); end
    end
  endtask

  // Write request dropped after one cycle still completes
  task automatic test_req_drop;
    exp_t e; int lat; logic [31:0] rv; longint ac;
    idle(2);
    e.data = 32'hDEAD_BEEF; e.lat = exp_lat(0); sb.push_back(e);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h2C; wdat[0] = 32'hA5A5_5A5A;
    @(posedge clk);
    #1;
    wr[0] = 1'b0; addr[0] = 32'hFFFF_FFF0; wdat[0] = 32'h0;
    lat = -1; rv = '0;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ack[0]) begin lat = n + 1; rv = rdat[0]; break; end
    end
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL drop latency: got %0d want %0d", lat, e.lat); end
    n_cmp++;
    if (rv !== e.data) begin n_bad++; $display("FAIL drop rdata: got %h want %h", rv, e.data); end
    idle(2);
    e.data = 32'hA5A5_5A5A; e.lat = exp_lat(0); sb.push_back(e);
    run_txn(0, 1'b1, 1'b0, 32'h2C, 32'h0, lat, rv, ac);
    e = sb.pop_front();
    n_cmp++;
    if (rv !== e.data) begin n_bad++; $display("FAIL drop readback: got %h want %h", rv, e.data); end
  endtask

  task automatic test_wait0_back_to_back;
    op_t ops [$];
    exp_t e; int lat; logic [31:0] rv; longint ac;
    logic [31:0] vals [3] = '{32'h44, 32'h88, 32'hCC};
    int lat_a [3]; logic [31:0] rd_a [3]; longint ac_a [3];
    ops.push_back(mk(1'b0, 1'b1, 32'h0, 32'h0, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h4, 32'h44, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h8, 32'h88, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'hC, 32'hCC, 32'h0));
    foreach (ops[i]) begin
      idle(2);
      e.data = ops[i].e; e.lat = exp_lat(1); sb.push_back(e);
      run_txn(1, ops[i].r, ops[i].w, ops[i].a, ops[i].d, lat, rv, ac);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL wait0[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (rv !== e.data) begin n_bad++; $display("FAIL wait0[%0d] rdata: got %h want %h", i, rv, e.data); end
    end
    // Three reads issued as soon as each ack is seen: acks W+3 cycles apart
    idle(2);
    for (int i = 0; i < 3; i++) begin
      e.data = vals[i]; e.lat = (i == 0) ? exp_lat(1) : int'(W1) + 3; sb.push_back(e);
      run_txn(1, 1'b1, 1'b0, 32'(4 * (i + 1)), 32'h0, lat_a[i], rd_a[i], ac_a[i]);
    end
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      lat = (i == 0) ? lat_a[0] : int'(ac_a[i] - ac_a[i-1]);
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL b2b[%0d] spacing: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (rd_a[i] !== e.data) begin n_bad++; $display("FAIL b2b[%0d] rdata: got %h want %h", i, rd_a[i], e.data); end
    end
    idle(1);
    n_cmp++;
    if (ack[1] !== 1'b0) begin n_bad++; $display("FAIL b2b ack_width: got %b want 0", ack[1]); end
  endtask

  task automatic test_region;
    op_t ops [$];
    exp_t e; int lat; logic [31:0] rv; longint ac;
    ops.push_back(mk(1'b0, 1'b1, 32'h1000, 32'h11, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h103C, 32'h77, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h0FFC, 32'h55, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h1040, 32'h55, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h11));
    ops.push_back(mk(1'b1, 1'b0, 32'h103C, 32'h0, 32'h77));
    ops.push_back(mk(1'b1, 1'b0, 32'h0FFC, 32'h0, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h11));
    ops.push_back(mk(1'b1, 1'b0, 32'h1040, 32'h0, 32'h0));
    ops.push_back(mk(1'b0, 1'b1, 32'h103C, 32'h55, 32'h0));
    ops.push_back(mk(1'b1, 1'b0, 32'h103C, 32'h0, 32'h55));
    foreach (ops[i]) begin
      idle(2);
      e.data = ops[i].e; e.lat = exp_lat(2); sb.push_back(e);
      run_txn(2, ops[i].r, ops[i].w, ops[i].a, ops[i].d, lat, rv, ac);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL region[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (rv !== e.data) begin n_bad++; $display("FAIL region[%0d] rdata: got %h want %h", i, rv, e.data); end
    end
  endtask

  task automatic test_reset_mid;
    op_t ops [$];
    exp_t e; int lat; logic [31:0] rv; longint ac;
    ops.push_back(mk(1'b0, 1'b1, 32'h20, 32'h1111_2222, 32'hA5A5_5A5A));
    ops.push_back(mk(1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_2222));
    foreach (ops[i]) begin
      idle(2);
      e.data = ops[i].e; e.lat = exp_lat(0); sb.push_back(e);
      run_txn(0, ops[i].r, ops[i].w, ops[i].a, ops[i].d, lat, rv, ac);
      e = sb.pop_front();
      n_cmp++;
      if (rv !== e.data) begin n_bad++; $display("FAIL rstmid_pre[%0d] rdata: got %h want %h", i, rv, e.data); end
    end
    idle(2);
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdat[0] = 32'h9999_0000;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid ack: got %b want 0", ack[0]); end
    n_cmp++;
    if (rdat[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid rdata: got %h want 0", rdat[0]); end
    wr[0] = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      n_cmp++;
      if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid late_ack[%0d]: got %b want 0", i, ack[0]); end
    end
    e.data = 32'h1111_2222; e.lat = exp_lat(0); sb.push_back(e);
    run_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, rv, ac);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL rstmid read latency: got %0d want %0d", lat, e.lat); end
    n_cmp++;
    if (rv !== e.data) begin n_bad++; $display("FAIL rstmid readback: got %h want %h", rv, e.data); end
  endtask

`ifdef MEM_RESPONDER_DEBUG_EN
  task automatic test_debug;
    int lat; logic [31:0] rv; longint ac;
    idle(2);
    run_txn(0, 1'b0, 1'b1, 32'h0C, 32'hCAFE_0042, lat, rv, ac);
    idle(1);
    n_cmp++;
    if (dbg[0] !== 32'h0003_0042) begin n_bad++; $display("FAIL debug write: got %h want 00030042", dbg[0]); end
    idle(2);
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, rv, ac);
    idle(1);
    n_cmp++;
    if (dbg[0] !== 32'h0004_BEEF) begin n_bad++; $display("FAIL debug read: got %h want 0004beef", dbg[0]); end
  endtask
`endif

  initial begin
    for (int s = 0; s < 3; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdat[s] = '0;
    end
    test_reset();
    test_wait2();
    test_both_req();
    test_req_drop();
    test_wait0_back_to_back();
    test_region();
    test_reset_mid();
`ifdef MEM_RESPONDER_DEBUG_EN
    test_debug();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
